seg7_scan_driver: RTL and testbench

Downstream consumer of the 5-bit synchronous up/down counter value (0..31). Converts the count to two BCD digits and time-multiplexes them onto one 7-segment bus with one-hot digit selects. The input is sampled once per scan frame, so a displayed frame never mixes digits from two different count values. Sits between the counter and board-level display pins.

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/bin5_to_bcd.sv | 32 +++
 rtl/seg7_scan_driver.sv | 118 +++++++++++
 tb/tb_seg7_scan_driver.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the 7-segment scan driver.
// Optional build macro: SEG7_BLANK_LEADING_ZERO_EN blanks the tens digit when it is zero.
package seg7_pkg;

  typedef enum logic {
    DIG_ONES = 1'b0,
    DIG_TENS = 1'b1
  } dig_state_e;

  // Active-high patterns, bit0=a .. bit6=g
  localparam logic [6:0] SEG_LUT [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
    7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };

  localparam logic [6:0] SEG_OFF = 7'h00;
  localparam logic [1:0] DIG_OFF = 2'b00;

  function automatic logic [6:0] seg_enc(input logic [3:0] digit);
    logic [6:0] pattern;
    if (digit <= 4'd9) begin
      pattern = SEG_LUT[digit];
    end else begin
      pattern = SEG_OFF;
    end
    return pattern;
  endfunction

endpackage

// File: rtl/bin5_to_bcd.sv
// Combinational 0..31 binary to two-digit BCD split using a compare chain.
module bin5_to_bcd
  import seg7_pkg::*;
(
  input  logic [4:0] bin,
  output logic [1:0] tens,
  output logic [3:0] ones
);

  logic [4:0] rem_s;

  // Subtract the largest multiple of ten not exceeding the input
  always_comb begin
    tens  = 2'd0;
    rem_s = bin;
    if (bin >= 5'd30) begin
      tens  = 2'd3;
      rem_s = bin - 5'd30;
    end else if (bin >= 5'd20) begin
      tens  = 2'd2;
      rem_s = bin - 5'd20;
    end else if (bin >= 5'd10) begin
      tens  = 2'd1;
      rem_s = bin - 5'd10;
    end else begin
      tens  = 2'd0;
      rem_s = bin;
    end
    ones = rem_s[3:0];
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Two-digit multiplexed 7-segment driver for a 0..31 count, latched once per scan frame.
// Optional build macro: SEG7_BLANK_LEADING_ZERO_EN (blank the tens digit when it is zero).
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV       = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] count_in,
  output logic [6:0] seg,
  output logic [1:0] dig_sel,
  output logic       frame_start
);

  localparam int              DW       = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [6:0]      SEG_INV  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic [1:0]      DIG_INV  = SEG_ACTIVE_LOW ? 2'b11 : 2'b00;

  dig_state_e    state_r, state_s;
  logic [DW-1:0] div_cnt_r, div_cnt_s;
  logic          wrap_s, frame_wrap_s;
  logic [4:0]    held_r;
  logic          load_pend_r;
  logic          frame_start_r;
  logic [6:0]    seg_r, seg_s;
  logic [1:0]    dig_sel_r, dig_sel_s;
  logic [1:0]    tens_s;
  logic [3:0]    ones_s;

  bin5_to_bcd u_bcd (
    .bin  (held_r),
    .tens (tens_s),
    .ones (ones_s)
  );

  // Slot divider and ones/tens state sequencing
  always_comb begin
    wrap_s    = (div_cnt_r == DIV_LAST);
    div_cnt_s = div_cnt_r + DW'(1);
    state_s   = state_r;
    if (wrap_s) begin
      div_cnt_s = {DW{1'b0}};
      state_s   = (state_r == DIG_ONES) ? DIG_TENS : DIG_ONES;
    end else begin
      div_cnt_s = div_cnt_r + DW'(1);
      state_s   = state_r;
    end
    frame_wrap_s = wrap_s && (state_r == DIG_TENS);
  end

  // Digit select and segment pattern for the slot being scanned
  always_comb begin
    seg_s     = SEG_OFF;
    dig_sel_s = DIG_OFF;
    case (state_r)
      DIG_ONES: begin
        dig_sel_s = 2'b01;
        seg_s     = seg_enc(ones_s);
      end
      DIG_TENS: begin
        dig_sel_s = 2'b10;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
        if (tens_s == 2'd0) begin
          seg_s = SEG_OFF;
        end else begin
          seg_s = seg_enc({2'b00, tens_s});
        end
`else
        seg_s = seg_enc({2'b00, tens_s});
`endif
      end
      default: begin
        dig_sel_s = DIG_OFF;
        seg_s     = SEG_OFF;
      end
    endcase
  end

  // State and divider registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= DIG_ONES;
      div_cnt_r <= {DW{1'b0}};
    end else begin
      state_r   <= state_s;
      div_cnt_r <= div_cnt_s;
    end
  end

  // Frame latch of the count plus registered, polarity-adjusted outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_r        <= 5'd0;
      load_pend_r   <= 1'b1;
      frame_start_r <= 1'b0;
      seg_r         <= SEG_OFF ^ SEG_INV;
      dig_sel_r     <= DIG_OFF ^ DIG_INV;
    end else begin
      frame_start_r <= frame_wrap_s;
      if (load_pend_r) begin
        held_r      <= count_in;
        load_pend_r <= 1'b0;
      end else if (frame_wrap_s) begin
        held_r <= count_in;
      end
      seg_r     <= seg_s ^ SEG_INV;
      dig_sel_r <= dig_sel_s ^ DIG_INV;
    end
  end

  assign seg         = seg_r;
  assign dig_sel     = dig_sel_r;
  assign frame_start = frame_start_r;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized self-checking bench: an active-high and an active-low instance checked against a frame-level model.
module tb_seg7_scan_driver;

  localparam int SD = 4;
`ifdef SEG7_BLANK_LEADING_ZERO_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif
  localparam logic [6:0] SEG_TAB [10] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F
  };
  localparam logic [18:0] RESET_BUNDLE = {7'h00, 2'b00, 1'b0, 7'h7F, 2'b11};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] count_in = 5'd0;
  logic [6:0] seg_h, seg_l;
  logic [1:0] dig_h, dig_l;
  logic       fs_h, fs_l;

  int passed = 0;
  int total  = 0;
  int edge_n = 0;
  logic [4:0] sampled [0:255];

  seg7_scan_driver #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst(rst), .count_in(count_in),
    .seg(seg_h), .dig_sel(dig_h), .frame_start(fs_h)
  );

  seg7_scan_driver #(.SCAN_DIV(SD), .SEG_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst(rst), .count_in(count_in),
    .seg(seg_l), .dig_sel(dig_l), .frame_start(fs_l)
  );

  always #5 clk = ~clk;

  // Displayed value after edge n: latched on the first edge after reset and at every frame end before n
  function automatic int held_at(int n);
    int latch_edge;
    if (n <= 1) return 0;
    latch_edge = ((n - 1) / (2 * SD)) * (2 * SD);
    if (latch_edge == 0) latch_edge = 1;
    return int'(sampled[latch_edge]);
  endfunction

  function automatic logic [18:0] exp_bundle(int n);
    int h;
    int slot;
    logic [6:0] s;
    logic [1:0] d;
    logic f;
    h    = held_at(n);
    slot = ((n - 1) / SD) % 2;
    if (slot == 0) begin
      s = SEG_TAB[h % 10];
      d = 2'b01;
    end else begin
      s = (BLANK && h < 10) ? 7'h00 : SEG_TAB[h / 10];
      d = 2'b10;
    end
    f = ((n % (2 * SD)) == 0);
    return {s, d, f, ~s, ~d};
  endfunction

  function automatic logic [18:0] obs_bundle();
    return {seg_h, dig_h, fs_h, seg_l, dig_l};
  endfunction

  task automatic tick();
    @(posedge clk);
    edge_n++;
    sampled[edge_n] = count_in;
    #1;
  endtask

  task automatic apply_reset(input logic [4:0] v);
    @(negedge clk);
    rst = 1'b1;
    count_in = v;
    #2;
    rst = 1'b0;
    edge_n = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    total++;
    if (obs_bundle() !== RESET_BUNDLE)
      $display("FAIL reset_async got=%h exp=%h", obs_bundle(), RESET_BUNDLE);
    else passed++;
    @(posedge clk);
    #1;
    total++;
    if (obs_bundle() !== RESET_BUNDLE)
      $display("FAIL reset_held got=%h exp=%h", obs_bundle(), RESET_BUNDLE);
    else passed++;
  endtask

  task automatic test_static_count();
    apply_reset(5'd27);
    for (int i = 0; i < 24; i++) begin
      tick();
      total++;
      if (obs_bundle() !== exp_bundle(edge_n))
        $display("FAIL static27 edge=%0d got=%h exp=%h", edge_n, obs_bundle(), exp_bundle(edge_n));
      else passed++;
    end
  endtask

  task automatic test_mid_frame_change();
    apply_reset(5'd19);
    for (int i = 0; i < 32; i++) begin
      tick();
      total++;
      if (obs_bundle() !== exp_bundle(edge_n))
        $display("FAIL midframe edge=%0d got=%h exp=%h", edge_n, obs_bundle(), exp_bundle(edge_n));
      else passed++;
      if (edge_n == 10) count_in = 5'd20;
    end
  endtask

  task automatic test_boundaries();
    logic [4:0] vals [4];
    vals = '{5'd0, 5'd9, 5'd10, 5'd31};
    for (int k = 0; k < 4; k++) begin
      apply_reset(vals[k]);
      for (int i = 0; i < 16; i++) begin
        tick();
        total++;
        if (obs_bundle() !== exp_bundle(edge_n))
          $display("FAIL boundary v=%0d edge=%0d got=%h exp=%h", vals[k], edge_n, obs_bundle(), exp_bundle(edge_n));
        else passed++;
      end
    end
  endtask

  task automatic test_async_reset();
    apply_reset(5'd27);
    for (int i = 0; i < 6; i++) tick();
    #3;
    rst = 1'b1;
    #1;
    total++;
    if (obs_bundle() !== RESET_BUNDLE)
      $display("FAIL async_reset_midtens got=%h exp=%h", obs_bundle(), RESET_BUNDLE);
    else passed++;
    apply_reset(5'd13);
    for (int i = 0; i < 16; i++) begin
      tick();
      total++;
      if (obs_bundle() !== exp_bundle(edge_n))
        $display("FAIL after_async edge=%0d got=%h exp=%h", edge_n, obs_bundle(), exp_bundle(edge_n));
      else passed++;
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      apply_reset(5'($urandom_range(0, 31)));
      for (int i = 0; i < 40; i++) begin
        tick();
        total++;
        if (obs_bundle() !== exp_bundle(edge_n))
          $display("FAIL random r=%0d edge=%0d got=%h exp=%h", r, edge_n, obs_bundle(), exp_bundle(edge_n));
        else passed++;
        count_in = 5'($urandom_range(0, 31));
      end
    end
  endtask

  initial begin
    test_reset();
    test_static_count();
    test_mid_frame_change();
    test_boundaries();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
